// File: rtl/conv_ctrl_pkg.sv
// conv_ctrl_pkg: shared types for the 3x3 convolution kernel sequencer.
package conv_ctrl_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_W,
        S_RUN,
        S_DRAIN,
        S_DONE
    } ctrl_state_t;

    localparam int OFMAP_W = 18;

    typedef struct packed {
        logic [OFMAP_W-1:0] ch1;
        logic [OFMAP_W-1:0] ch2;
        logic               last;
    } ofmap_pair_t;

endpackage

// File: rtl/conv_kernel_ctrl_ofmap_fifo.sv
// ofmap_fifo: shift-register FIFO; the head always sits in mem[0] so outputs come straight from flops.
module ofmap_fifo
    import conv_ctrl_pkg::*;
#(
    parameter int  DEPTH = 8,
    parameter type T     = ofmap_pair_t
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  T                           din,
    input  logic                       pop,
    output T                           head,
    output logic                       valid,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;

    T              mem [DEPTH];
    logic [CW-1:0] wr_pos;
    logic          do_pop;
    logic          do_push;

    assign do_pop  = pop && count != '0;
    assign wr_pos  = count - CW'(do_pop);
    assign do_push = push && 32'(wr_pos) < DEPTH;
    assign head    = mem[0];
    assign valid   = count != '0;

    // Slots above count are kept zero so an empty FIFO presents an all-zero head.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (do_pop) begin
                for (int i = 0; i < DEPTH - 1; i++) mem[i] <= mem[i+1];
                mem[DEPTH-1] <= '0;
            end
            if (do_push) mem[wr_pos[AW-1:0]] <= din;
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/conv_kernel_ctrl.sv
// conv_kernel_ctrl: walks all 3x3 windows of a map in raster order, tracks kernel latency
// and buffers ofmap pairs in an output FIFO under credit-based backpressure.
module conv_kernel_ctrl
    import conv_ctrl_pkg::*;
#(
    parameter int KERNEL_LAT = 4,
    parameter int FIFO_DEPTH = 8,
    parameter int DIM_W      = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [DIM_W-1:0]   cfg_w,
    input  logic [DIM_W-1:0]   cfg_h,
    output logic               busy,
    output logic               done,
    output logic               err,
    output logic               wgt_latch,
    output logic               win_valid,
    output logic [DIM_W-1:0]   win_row,
    output logic [DIM_W-1:0]   win_col,
    input  logic [OFMAP_W-1:0] ofmap_ch1,
    input  logic [OFMAP_W-1:0] ofmap_ch2,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [OFMAP_W-1:0] out_ch1,
    output logic [OFMAP_W-1:0] out_ch2,
    output logic               out_last
);
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    ctrl_state_t           state, state_nx;
    logic [DIM_W-1:0]      w_q, h_q, row, col;
    logic [KERNEL_LAT-1:0] vld_sr, last_sr;
    logic [CW-1:0]         fifo_count;
    logic                  err_q, pop, tap, credit_ok, last_col, last_win, illegal;
    ofmap_pair_t           head;

    assign illegal   = cfg_w < DIM_W'(3) || cfg_h < DIM_W'(3);
    assign pop       = out_valid && out_ready;
    assign tap       = vld_sr[KERNEL_LAT-1];
    // Credit counts the post-pop occupancy plus every window still inside the kernel.
    assign credit_ok = 32'(fifo_count) + 32'($countones(vld_sr)) < 32'(FIFO_DEPTH) + 32'(pop);
    assign last_col  = col == w_q - DIM_W'(3);
    assign last_win  = last_col && row == h_q - DIM_W'(3);

    assign win_valid = state == S_RUN && credit_ok;
    assign busy      = state inside {S_LOAD_W, S_RUN, S_DRAIN};
    assign done      = state == S_DONE;
    assign wgt_latch = state == S_LOAD_W;
    assign err       = err_q;
    assign win_row   = row;
    assign win_col   = col;
    assign out_ch1   = head.ch1;
    assign out_ch2   = head.ch2;
    assign out_last  = head.last;

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:   state_nx = start ? (illegal ? S_DONE : S_LOAD_W) : S_IDLE;
            S_LOAD_W: state_nx = S_RUN;
            S_RUN:    state_nx = win_valid && last_win ? S_DRAIN : S_RUN;
            S_DRAIN:  state_nx = pop && head.last ? S_DONE : S_DRAIN;
            S_DONE:   state_nx = S_IDLE;
            default:  state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            w_q     <= '0;
            h_q     <= '0;
            row     <= '0;
            col     <= '0;
            err_q   <= 1'b0;
            vld_sr  <= '0;
            last_sr <= '0;
        end else begin
            state   <= state_nx;
            vld_sr  <= (vld_sr << 1) | KERNEL_LAT'(win_valid);
            last_sr <= (last_sr << 1) | KERNEL_LAT'(win_valid && last_win);
            if (state == S_IDLE && start) begin
                w_q   <= cfg_w;
                h_q   <= cfg_h;
                err_q <= illegal;
                row   <= '0;
                col   <= '0;
            end
            if (win_valid) begin
                col <= last_col ? '0 : col + 1'b1;
                row <= last_col ? (last_win ? '0 : row + 1'b1) : row;
            end
        end
    end

    ofmap_fifo #(.DEPTH(FIFO_DEPTH), .T(ofmap_pair_t)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (tap),
        .din   ('{ch1: ofmap_ch1, ch2: ofmap_ch2, last: last_sr[KERNEL_LAT-1]}),
        .pop   (pop),
        .head  (head),
        .valid (out_valid),
        .count (fifo_count)
    );

    assert property (@(posedge clk) disable iff (rst) tap && !pop |-> 32'(fifo_count) < FIFO_DEPTH)
        else $error("ofmap FIFO overflow");

endmodule
